// File: rtl/shift_fifo_pkg.sv
// shift_fifo_pkg: shared constants, delay-state type and helper functions for shift_fifo_param
package shift_fifo_pkg;
  localparam int DEF_DATA_W = 128;
  localparam int DEF_DEPTH = 4;
  typedef enum logic {APPLIED = 1'b0, PENDING = 1'b1} delay_state_e;
  function automatic int sel_width(input int depth);
    return $clog2(depth + 1);
  endfunction
  // Requests outside 1..depth are pulled to the nearest legal delay.
  function automatic int clamp_delay(input int sel, input int depth);
    return sel < 1 ? 1 : (sel > depth ? depth : sel);
  endfunction
endpackage

// File: rtl/shift_fifo_stage.sv
// shift_fifo_stage: one data+valid pipeline register with shift enable, flush and sync active-low reset
//   clk, reset_n      : clock, synchronous active-low reset
//   en_i, flush_i     : shift enable, clear valid (flush wins over en)
//   data_i, valid_i   : entry from the previous stage (or din)
//   data_o, valid_o   : registered entry
//   Build option SHIFT_FIFO_ZERO_INVALID_EN: flush and invalid loads zero the data register.
module shift_fifo_stage import shift_fifo_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o
);
  logic [DATA_W-1:0] data_q, data_d;
  logic              vld_q, vld_d;
  always_comb begin
    vld_d = flush_i ? 1'b0 : (en_i ? valid_i : vld_q);
`ifdef SHIFT_FIFO_ZERO_INVALID_EN
    data_d = flush_i ? '0 : (en_i ? (valid_i ? data_i : '0) : data_q);
`else
    data_d = (en_i && !flush_i) ? data_i : data_q;
`endif
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end
  assign data_o  = data_q;
  assign valid_o = vld_q;
endmodule

// File: rtl/shift_fifo_param.sv
// shift_fifo_param: parametrised shift-register delay FIFO with valid tracking, flush, occupancy and safe runtime delay tap
//   clk, reset_n              : clock, synchronous active-low reset
//   en, flush                 : shift enable, clear all valid bits (reset > flush > en)
//   din, din_valid            : entry captured into stage 0 on a shift
//   delay_sel, delay_load     : requested delay (clamped to 1..DEPTH) and apply request
//   dout, dout_valid          : entry at the active tap stage[cur_delay-1]
//   occupancy, empty          : count of valid entries, occupancy == 0
//   delay_busy, cur_delay     : a delay change is waiting for empty, delay in effect
//   Build option SHIFT_FIFO_ZERO_INVALID_EN: dout reads 0 when not valid, flush and invalid loads zero data.
module shift_fifo_param import shift_fifo_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int SEL_W  = sel_width(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic [SEL_W-1:0]  delay_sel,
  input  logic              delay_load,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic [SEL_W-1:0]  occupancy,
  output logic              empty,
  output logic              delay_busy,
  output logic [SEL_W-1:0]  cur_delay
);
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] in_data [DEPTH];
  logic [DEPTH-1:0]  vld_q, in_vld;
  logic [SEL_W-1:0]  occ_q, occ_d, cur_q, cur_d, pend_q, pend_d, clamped;
  logic [DATA_W-1:0] tap_data;
  logic              apply_now;
  delay_state_e      state_q, state_d;
  genvar k;
  for (k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign in_data[k] = din;
      assign in_vld[k]  = din_valid;
    end else begin : g_link
      assign in_data[k] = data_q[k-1];
      assign in_vld[k]  = vld_q[k-1];
    end
    shift_fifo_stage #(.DATA_W(DATA_W)) u_stage (
      .clk     (clk),
      .reset_n (reset_n),
      .en_i    (en),
      .flush_i (flush),
      .data_i  (in_data[k]),
      .valid_i (in_vld[k]),
      .data_o  (data_q[k]),
      .valid_o (vld_q[k])
    );
  end
  // Tap select as a compare-mux so the SEL_W-wide delay never indexes the array directly.
  always_comb begin
    tap_data   = '0;
    dout_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (cur_q == SEL_W'(i + 1)) begin
        tap_data   = data_q[i];
        dout_valid = vld_q[i];
      end
    end
  end
`ifdef SHIFT_FIFO_ZERO_INVALID_EN
  assign dout = dout_valid ? tap_data : '0;
`else
  assign dout = tap_data;
`endif
  assign clamped   = SEL_W'(clamp_delay(int'(delay_sel), DEPTH));
  // Changing the tap is only safe with nothing in flight, judged on the pre-edge count.
  assign apply_now = (occ_q == '0) || flush;
  always_comb begin
    occ_d   = flush ? '0 : (en ? occ_q + SEL_W'(din_valid) - SEL_W'(vld_q[DEPTH-1]) : occ_q);
    pend_d  = delay_load ? clamped : pend_q;
    state_d = state_q;
    cur_d   = cur_q;
    if (state_q == APPLIED) begin
      if (delay_load) begin
        cur_d   = apply_now ? clamped : cur_q;
        state_d = apply_now ? APPLIED : PENDING;
      end
    end else if (apply_now) begin
      cur_d   = pend_d;
      state_d = APPLIED;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      occ_q   <= '0;
      cur_q   <= SEL_W'(DEPTH);
      pend_q  <= SEL_W'(DEPTH);
      state_q <= APPLIED;
    end else begin
      occ_q   <= occ_d;
      cur_q   <= cur_d;
      pend_q  <= pend_d;
      state_q <= state_d;
    end
  end
  assign occupancy  = occ_q;
  assign empty      = (occ_q == '0);
  assign delay_busy = (state_q == PENDING);
  assign cur_delay  = cur_q;
endmodule
